// File: rtl/loop_seq_pkg.sv
// Shared types for the loop copy sequencer: FSM encoding and output reset values.
package loop_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic rd_en;
    logic wr_en;
  } ctl_t;

  localparam ctl_t CTL_RST = '{busy: 1'b0, done: 1'b0, rd_en: 1'b0, wr_en: 1'b0};

endpackage

// File: rtl/loop_array_mem.sv
// DEPTH x WIDTH register array with one registered read port and one write port.
module loop_array_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/loop_copy_sequencer.sv
// Executes mem[i] = mem[(i - SRC_OFF) mod DEPTH] for i = lo..hi, one element per
// read/write cycle pair, through the single read and write ports of an external array.
//
// state | meaning
// IDLE  | waiting for start; lo/hi latched on accept
// RD    | read strobe for source of element i
// WR    | write strobe for element i using the returned read data
// FIN   | one-cycle done pulse, then back to IDLE
module loop_copy_sequencer
  import loop_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 4,
  parameter int AW      = $clog2(DEPTH),
  parameter int SRC_OFF = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    lo_idx,
  input  logic [AW-1:0]    hi_idx,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [AW:0]      wr_count
);

  localparam logic [AW-1:0] OFF = AW'(SRC_OFF % DEPTH);

  state_t        state_q, state_d;
  ctl_t          ctl_q, ctl_d;
  logic [AW:0]   i_q, i_d;
  logic [AW-1:0] hi_q, hi_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic [AW:0]   i_inc;

  assign i_inc = i_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ctl_d      = CTL_RST;
    i_d        = i_q;
    hi_d       = hi_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          hi_d       = hi_idx;
          i_d        = {1'b0, lo_idx};
          wr_count_d = '0;
          if (lo_idx > hi_idx) begin
            state_d    = FIN;
            ctl_d.done = 1'b1;
          end else begin
            state_d     = RD;
            ctl_d.busy  = 1'b1;
            ctl_d.rd_en = 1'b1;
            rd_addr_d   = lo_idx - OFF;
          end
        end
      end
      RD: begin
        state_d     = WR;
        ctl_d.busy  = 1'b1;
        ctl_d.wr_en = 1'b1;
        wr_addr_d   = i_q[AW-1:0];
      end
      WR: begin
        wr_count_d = wr_count_q + 1'b1;
        // Equality test keeps hi = DEPTH-1 safe; i never needs to pass hi.
        if (i_q == {1'b0, hi_q}) begin
          state_d    = FIN;
          ctl_d.done = 1'b1;
        end else begin
          i_d         = i_inc;
          state_d     = RD;
          ctl_d.busy  = 1'b1;
          ctl_d.rd_en = 1'b1;
          rd_addr_d   = i_inc[AW-1:0] - OFF;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctl_q      <= CTL_RST;
      i_q        <= '0;
      hi_q       <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ctl_q      <= ctl_d;
      i_q        <= i_d;
      hi_q       <= hi_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;
  assign rd_en    = ctl_q.rd_en;
  assign wr_en    = ctl_q.wr_en;
  assign rd_addr  = rd_addr_q;
  assign wr_addr  = wr_addr_q;
  // Read data arrives in the WR cycle itself, so it is forwarded rather than registered.
  assign wr_data  = ctl_q.wr_en ? rd_data : '0;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_loop_copy_sequencer.sv
// Directed bench: two sequencers (SRC_OFF 0 and 1), each driving its own array.
module tb_loop_copy_sequencer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             ld_en, ld_sel;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;

  logic             start0, busy0, done0, rd_en0, wr_en0;
  logic [AW-1:0]    lo0, hi0, rd_addr0, wr_addr0;
  logic [WIDTH-1:0] rd_data0, wr_data0;
  logic [AW:0]      wr_count0;

  logic             start1, busy1, done1, rd_en1, wr_en1;
  logic [AW-1:0]    lo1, hi1, rd_addr1, wr_addr1;
  logic [WIDTH-1:0] rd_data1, wr_data1;
  logic [AW:0]      wr_count1;

  logic             m_we0, m_we1;
  logic [AW-1:0]    m_wa0, m_wa1;
  logic [WIDTH-1:0] m_wd0, m_wd1;

  // Bench preload shares the array write port; a write strobe coinciding with reset is aborted.
  assign m_we0 = (ld_en && !ld_sel) || (wr_en0 && !reset);
  assign m_wa0 = ld_en ? ld_addr : wr_addr0;
  assign m_wd0 = ld_en ? ld_data : wr_data0;
  assign m_we1 = (ld_en && ld_sel) || (wr_en1 && !reset);
  assign m_wa1 = ld_en ? ld_addr : wr_addr1;
  assign m_wd1 = ld_en ? ld_data : wr_data1;

  loop_copy_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SRC_OFF(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .lo_idx(lo0), .hi_idx(hi0),
    .busy(busy0), .done(done0), .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_count(wr_count0)
  );
  loop_array_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem0 (
    .clk(clk), .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_en(m_we0), .wr_addr(m_wa0), .wr_data(m_wd0)
  );

  loop_copy_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SRC_OFF(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .lo_idx(lo1), .hi_idx(hi1),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_count(wr_count1)
  );
  loop_array_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem1 (
    .clk(clk), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(m_we1), .wr_addr(m_wa1), .wr_data(m_wd1)
  );

  int checks = 0;
  int errors = 0;
  int wa [16];
  int wd [16];
  int ra [16];

  task automatic load_mem(input bit sel, input logic [WIDTH-1:0] v0, v1, v2, v3);
    logic [WIDTH-1:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_sel = sel; ld_addr = AW'(i); ld_data = v[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] mem_at(input bit sel, input int i);
    return sel ? u_mem1.mem_q[i] : u_mem0.mem_q[i];
  endfunction

  task automatic start_op(input bit sel, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    @(negedge clk);
    if (sel) begin lo1 = lo; hi1 = hi; start1 = 1'b1; end
    else     begin lo0 = lo; hi0 = hi; start0 = 1'b1; end
  endtask

  // Cycle c counts negedges after the start was driven; records writes, reads and dones.
  task automatic run_op(input bit sel, input bit hold, input int extra,
                        output int done_cyc, output int n_wr, output int n_rd, output int n_done);
    done_cyc = -1; n_wr = 0; n_rd = 0; n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (sel ? wr_en1 : wr_en0) begin
        wa[n_wr] = int'(sel ? wr_addr1 : wr_addr0);
        wd[n_wr] = int'(sel ? wr_data1 : wr_data0);
        n_wr++;
      end
      if (sel ? rd_en1 : rd_en0) begin
        ra[n_rd] = int'(sel ? rd_addr1 : rd_addr0);
        n_rd++;
      end
      if (sel ? done1 : done0) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (hold && c == 2) begin
        if (sel) begin lo1 = 2'd3; hi1 = 2'd1; end
        else     begin lo0 = 2'd3; hi0 = 2'd1; end
      end
      if (!hold || (done_cyc >= 0 && c > done_cyc)) begin
        if (sel) start1 = 1'b0; else start0 = 1'b0;
      end
      if (done_cyc >= 0 && c >= done_cyc + extra && (!hold || c > done_cyc)) break;
    end
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done pulse within 40 cycles");
      start0 = 1'b0; start1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; lo0 = '0; hi0 = '0; lo1 = '0; hi1 = '0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, done0, rd_en0, wr_en0} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl0: got %b want 0000", {busy0, done0, rd_en0, wr_en0});
    end
    checks++;
    if ({rd_addr0, wr_addr0, wr_data0, wr_count0} !== '0) begin
      errors++; $display("FAIL reset_data0: got %h want 0", {rd_addr0, wr_addr0, wr_data0, wr_count0});
    end
    checks++;
    if ({busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1, wr_count1} !== '0) begin
      errors++; $display("FAIL reset_dut1: got %h want 0",
                         {busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1, wr_count1});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_copy();
    int dc, nw, nr, nd;
    load_mem(1'b0, 4'd0, 4'd1, 4'd2, 4'd3);
    start_op(1'b0, 2'd2, 2'd3);
    run_op(1'b0, 1'b0, 1, dc, nw, nr, nd);
    checks++;
    if (dc !== 5) begin errors++; $display("FAIL t1_latency: got %0d want 5", dc); end
    checks++;
    if (nw !== 2 || wa[0] !== 2 || wd[0] !== 2 || wa[1] !== 3 || wd[1] !== 3) begin
      errors++; $display("FAIL t1_writes: got n=%0d (%0d,%0d)(%0d,%0d) want n=2 (2,2)(3,3)",
                         nw, wa[0], wd[0], wa[1], wd[1]);
    end
    checks++;
    if (wr_count0 !== 3'd2 || busy0 !== 1'b0) begin
      errors++; $display("FAIL t1_count: got wr_count=%0d busy=%b want 2 0", wr_count0, busy0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_at(1'b0, i) !== 4'(i)) begin
        errors++; $display("FAIL t1_mem[%0d]: got %h want %h", i, mem_at(1'b0, i), i);
      end
    end
  endtask

  task automatic test_offset_copy();
    int dc, nw, nr, nd;
    load_mem(1'b1, 4'hA, 4'hB, 4'hC, 4'hD);
    start_op(1'b1, 2'd1, 2'd3);
    run_op(1'b1, 1'b0, 1, dc, nw, nr, nd);
    checks++;
    if (dc !== 7) begin errors++; $display("FAIL t2_latency: got %0d want 7", dc); end
    checks++;
    if (nw !== 3 || wr_count1 !== 3'd3) begin
      errors++; $display("FAIL t2_count: got writes=%0d wr_count=%0d want 3 3", nw, wr_count1);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_at(1'b1, i) !== 4'hA) begin
        errors++; $display("FAIL t2_mem[%0d]: got %h want a", i, mem_at(1'b1, i));
      end
    end
  endtask

  task automatic test_empty_range();
    int dc, nw, nr, nd;
    start_op(1'b0, 2'd3, 2'd1);
    run_op(1'b0, 1'b0, 3, dc, nw, nr, nd);
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL t3_latency: got %0d want 1", dc); end
    checks++;
    if (nw !== 0 || nr !== 0 || wr_count0 !== 3'd0) begin
      errors++; $display("FAIL t3_no_access: got writes=%0d reads=%0d wr_count=%0d want 0 0 0",
                         nw, nr, wr_count0);
    end
  endtask

  task automatic test_wrap();
    int dc, nw, nr, nd;
    load_mem(1'b1, 4'd5, 4'd6, 4'd7, 4'b0011);
    start_op(1'b1, 2'd0, 2'd0);
    run_op(1'b1, 1'b0, 1, dc, nw, nr, nd);
    checks++;
    if (nr !== 1 || ra[0] !== 3) begin
      errors++; $display("FAIL t4_rd_addr: got n=%0d addr=%0d want n=1 addr=3", nr, ra[0]);
    end
    checks++;
    if (mem_at(1'b1, 0) !== 4'b0011 || dc !== 3 || wr_count1 !== 3'd1) begin
      errors++; $display("FAIL t4_result: got mem0=%h done=%0d wr_count=%0d want 3 3 1",
                         mem_at(1'b1, 0), dc, wr_count1);
    end
  endtask

  task automatic test_start_while_busy();
    int dc, nw, nr, nd;
    load_mem(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
    start_op(1'b0, 2'd0, 2'd3);
    run_op(1'b0, 1'b1, 3, dc, nw, nr, nd);
    checks++;
    if (nw !== 4 || nd !== 1 || dc !== 9) begin
      errors++; $display("FAIL t5_held_start: got writes=%0d dones=%0d done_at=%0d want 4 1 9",
                         nw, nd, dc);
    end
    checks++;
    if (wa[0] !== 0 || wa[1] !== 1 || wa[2] !== 2 || wa[3] !== 3 || wr_count0 !== 3'd4) begin
      errors++; $display("FAIL t5_no_resample: got addrs %0d %0d %0d %0d wr_count=%0d want 0 1 2 3 4",
                         wa[0], wa[1], wa[2], wa[3], wr_count0);
    end
  endtask

  task automatic test_reset_mid_run();
    int dc, nw, nr, nd, writes, dones;
    writes = 0; dones = 0;
    start_op(1'b0, 2'd0, 2'd3);
    // c1 RD, c2 WR, c3 RD, c4 second WR: reset raised there.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start0 = 1'b0;
      if (c < 4 && wr_en0) writes++;
    end
    checks++;
    if (wr_en0 !== 1'b1) begin errors++; $display("FAIL t6_second_wr: got wr_en=%b want 1", wr_en0); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || wr_en0 !== 1'b0) begin
      errors++; $display("FAIL t6_abort: got busy=%b wr_en=%b want 0 0", busy0, wr_en0);
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wr_en0) writes++;
      if (done0) dones++;
    end
    checks++;
    if (writes !== 1 || dones !== 0) begin
      errors++; $display("FAIL t6_after_reset: got writes=%0d dones=%0d want 1 0", writes, dones);
    end
    start_op(1'b0, 2'd1, 2'd2);
    run_op(1'b0, 1'b0, 1, dc, nw, nr, nd);
    checks++;
    if (dc !== 5 || nw !== 2 || wr_count0 !== 3'd2) begin
      errors++; $display("FAIL t6_restart: got done_at=%0d writes=%0d wr_count=%0d want 5 2 2",
                         dc, nw, wr_count0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_offset_copy();
    test_empty_range();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
